// File: rtl/systolic_row.sv
// systolic_row: one row of N multiply-accumulate PEs. Operand a enters PE0 and
// shifts one PE per cycle; each PE multiplies its a by its own b_in lane and
// accumulates locally. A drain pulse stops intake, lets in-flight samples land
// (FLUSH), then reads acc_0 .. acc_{N-1} out serially on c_out (DRAIN).
// Build option: define SYSTOLIC_ROW_SAT_EN for saturating accumulation;
// otherwise accumulators wrap modulo 2^ACC_W.
module systolic_row #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     a_in,
    input  logic [N*DATA_W-1:0]   b_in,
    input  logic                  clear,
    input  logic                  drain,
    output logic [DATA_W-1:0]     a_out,
    output logic                  a_valid_out,
    output logic [ACC_W-1:0]      c_out,
    output logic                  c_valid,
    output logic                  busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]               state;
    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] a_stage [N];
    logic [N-1:0]             v_stage;
    logic signed [ACC_W-1:0]  acc      [N];
    logic signed [ACC_W-1:0]  acc_next [N];
    logic                     acc_clr;
    logic                     drain_last;

    assign busy        = (state != ST_ACC);
    assign c_valid     = (state == ST_DRAIN);
    assign c_out       = c_valid ? acc[idx] : '0;
    assign a_out       = a_stage[N-1];
    assign a_valid_out = v_stage[N-1];
    assign acc_clr     = clear && (state != ST_DRAIN);
    assign drain_last  = (state == ST_DRAIN) && (idx == IDX_W'(N - 1));

    for (genvar k = 0; k < N; k++) begin : g_pe
        logic signed [DATA_W-1:0]   b_k;
        logic signed [2*DATA_W-1:0] prod;
        logic signed [ACC_W-1:0]    base;

        assign b_k  = b_in[k*DATA_W +: DATA_W];
        assign prod = a_stage[k] * b_k;
        assign base = acc_clr ? '0 : acc[k];

`ifdef SYSTOLIC_ROW_SAT_EN
        // One guard bit: disagreement between the top two bits flags overflow.
        logic signed [ACC_W:0] sum;
        assign sum = {base[ACC_W-1], base}
                   + (v_stage[k] ? {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod} : '0);
        assign acc_next[k] = (sum[ACC_W] != sum[ACC_W-1])
                           ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                         : {1'b0, {(ACC_W-1){1'b1}}})
                           : sum[ACC_W-1:0];
`else
        logic signed [ACC_W-1:0] sum;
        assign sum = base
                   + (v_stage[k] ? {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod} : '0);
        assign acc_next[k] = sum;
`endif
    end

    // Operand shift pipeline; intake is gated off while flushing or draining.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < N; k++) a_stage[k] <= '0;
            v_stage <= '0;
        end else begin
            a_stage[0] <= a_in;
            v_stage[0] <= in_valid & ~busy;
            for (int unsigned k = 1; k < N; k++) begin
                a_stage[k] <= a_stage[k-1];
                v_stage[k] <= v_stage[k-1];
            end
        end
    end

    // Accumulators; all zeroed as the last drain beat is presented.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < N; k++) acc[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < N; k++)
                acc[k] <= drain_last ? '0 : acc_next[k];
        end
    end

    // Control FSM: ACC -> FLUSH on drain, FLUSH -> DRAIN once pipeline is empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_ACC;
            idx   <= '0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (drain) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (v_stage == '0) begin
                        state <= ST_DRAIN;
                        idx   <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        state <= ST_ACC;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= ST_ACC;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/systolic_row.md
SYSTOLIC_ROW -- requirements
Module: systolic_row

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of processing elements (PEs) in the row, with N >= 2.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the width of the signed operands.
REQ-003 The block SHALL have parameter ACC_W, default 20, meaning the width of the signed accumulators, with ACC_W >= 2*DATA_W.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a_in carries a sample this cycle.
REQ-007 The block SHALL have port a_in, input, DATA_W bits: signed operand entering PE0.
REQ-008 The block SHALL have port b_in, input, N*DATA_W bits: lane k (bits k*DATA_W upward) is the signed operand for PE k, sampled unregistered; skew is the host's job.
REQ-009 The block SHALL have port clear, input, 1 bit: zero all accumulators.
REQ-010 The block SHALL have port drain, input, 1-cycle pulse: request serial readout.
REQ-011 The block SHALL have port a_out, output, DATA_W bits: operand leaving PE N-1, for chaining.
REQ-012 The block SHALL have port a_valid_out, output, 1 bit: a_out valid.
REQ-013 The block SHALL have port c_out, output, ACC_W bits: drained accumulator value.
REQ-014 The block SHALL have port c_valid, output, 1 bit: c_out valid.
REQ-015 The block SHALL have port busy, output, 1 bit: high in FLUSH or DRAIN; in_valid is ignored while high.

Function
REQ-016 Operand pipeline: stage 0 SHALL register a_in and (in_valid & ~busy); stage k SHALL register stage k-1, so a sample reaches stage k after k+1 edges.
REQ-017 a_out/a_valid_out SHALL be stage N-1, giving a latency of N cycles from a_in.
REQ-018 At each edge with stage-k valid, acc_k SHALL become (clear ? 0 : acc_k) + sext(a_k * b_in lane k); with stage-k valid low, acc_k SHALL become clear ? 0 : acc_k.
REQ-019 The product SHALL be a signed 2*DATA_W two's-complement value, sign-extended to ACC_W; overflow handling SHALL follow REQ-026.
REQ-020 The FSM SHALL have the states ACC, FLUSH and DRAIN.
- ACC -> FLUSH on drain=1.
- FLUSH -> DRAIN when all stage valids are 0, checked each cycle including the entry cycle.
- DRAIN SHALL last exactly N cycles, outputting acc_0 first and acc_{N-1} last, with c_valid=1 in each; then go to ACC with all accumulators zeroed.
REQ-021 Accumulation during FLUSH SHALL continue for in-flight samples; the drain input SHALL be ignored outside ACC; clear SHALL be ignored in DRAIN.
REQ-022 When c_valid=0, c_out SHALL be 0.

Reset
REQ-023 On reset=1 at an edge, the block SHALL force state ACC, zero all accumulators, zero all pipeline stages and valids, and drive a_out=0, a_valid_out=0, c_out=0, c_valid=0 and busy=0.
REQ-024 Reset SHALL override every other input, including mid-FLUSH or mid-DRAIN: the drain is aborted and no further c_valid is issued.

Configuration
REQ-025 The block SHALL use macro SYSTOLIC_ROW_SAT_EN to select overflow handling.
REQ-026 When SYSTOLIC_ROW_SAT_EN is defined, accumulation SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; when it is undefined, accumulation SHALL wrap modulo 2^ACC_W.

Verification
REQ-027 Reset check: assert reset for 2 cycles with random inputs -> all outputs 0, busy=0.
REQ-028 Latency and drain check: a_in=3 with in_valid for 1 cycle, all b lanes=2; pulse drain 6 cycles later ->
- a_out=3 with a_valid_out=1 exactly 4 edges after the input edge;
- then c_out=6,6,6,6 with c_valid for 4 consecutive cycles;
- a second drain then yields 0,0,0,0.
REQ-029 Flush check: in_valid with a_in=5 at cycle t, b lanes=1,2,3,4, drain at t+1 ->
- busy rises;
- in_valid at t+2 is dropped;
- DRAIN starts only after stage 3 clears;
- c_out=5,10,15,20.
REQ-030 Overflow check: 32 samples of a=-128 with every b lane=-128 ->
- without SYSTOLIC_ROW_SAT_EN, c_out=-524288 for each lane;
- with SYSTOLIC_ROW_SAT_EN, c_out=524287.
REQ-031 Clear check: clear and a valid product of 7 on the same edge after prior accumulation -> drained value 7.
REQ-032 Reset-mid-drain check: assert reset during the 2nd DRAIN cycle -> c_valid=0 and busy=0 next cycle, and a subsequent drain yields all zeros.
